// File: rtl/cycle_db_bank_if.sv
// Control/data bundle for cycle_db_bank: shadow load, queue commit/transfer,
// shift control on the input side; active registers, queue status and
// sticky error flags on the output side.
interface cycle_db_bank_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 4
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int NW = CHANNELS * WIDTH;
    localparam int KW = $clog2(DEPTH) + 1;

    logic                LOAD;
    logic [CW-1:0]       LOAD_CH;
    logic [WIDTH-1:0]    D;
    logic                COMMIT;
    logic                TRANSFER;
    logic                STEP;
    logic                MODE;
    logic                CLR_ERR;
    logic [NW-1:0]       Q;
    logic [CHANNELS-1:0] SER;
    logic [KW-1:0]       COUNT;
    logic                FULL;
    logic                EMPTY;
    logic                OVF;
    logic                UNF;

    modport master (
        output LOAD, LOAD_CH, D, COMMIT, TRANSFER, STEP, MODE, CLR_ERR,
        input  Q, SER, COUNT, FULL, EMPTY, OVF, UNF
    );

    modport slave (
        input  LOAD, LOAD_CH, D, COMMIT, TRANSFER, STEP, MODE, CLR_ERR,
        output Q, SER, COUNT, FULL, EMPTY, OVF, UNF
    );
endinterface

// File: rtl/cycle_db_bank.sv
// Double-buffered multi-channel cycle register bank.
// A shadow set is edited word by word, committed whole into a small FIFO,
// and popped into the active shift/rotate registers on TRANSFER.
module cycle_db_bank #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 4
) (
    input logic            CLK,
    input logic            RST,
    cycle_db_bank_if.slave bus
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int NW = CHANNELS * WIDTH;
    localparam int PW = $clog2(DEPTH);
    localparam int KW = PW + 1;
    localparam logic [KW-1:0] FULL_CNT = KW'(DEPTH);

    logic [NW-1:0] shadow_q, shadow_d;
    logic [NW-1:0] mem_q [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [KW-1:0] count_q, count_d;
    logic [NW-1:0] act_q, act_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          do_push, do_pop;

    // Shadow next value; the written word is visible to a same-cycle COMMIT.
    // Out-of-range channel selects simply match no channel.
    always_comb begin
        shadow_d = shadow_q;
        for (int c = 0; c < CHANNELS; c++) begin
            if (bus.LOAD && (bus.LOAD_CH == CW'(c))) begin
                shadow_d[c*WIDTH +: WIDTH] = bus.D;
            end else begin
                shadow_d[c*WIDTH +: WIDTH] = shadow_q[c*WIDTH +: WIDTH];
            end
        end
    end

    // Queue control: pop is evaluated first so a full queue accepts a push
    // in the same cycle as a transfer.
    always_comb begin
        do_pop  = bus.TRANSFER && (count_q != {KW{1'b0}});
        do_push = bus.COMMIT && ((count_q != FULL_CNT) || do_pop);
        if (do_push && !do_pop) begin
            count_d = count_q + KW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - KW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Sticky error flags: a new event in the same cycle beats CLR_ERR.
    always_comb begin
        if (bus.COMMIT && !do_push) begin
            ovf_d = 1'b1;
        end else if (bus.CLR_ERR) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (bus.TRANSFER && (count_q == {KW{1'b0}})) begin
            unf_d = 1'b1;
        end else if (bus.CLR_ERR) begin
            unf_d = 1'b0;
        end else begin
            unf_d = unf_q;
        end
    end

    // Active registers: TRANSFER (even an underflowing one) suppresses STEP.
    always_comb begin
        act_d = act_q;
        if (bus.TRANSFER) begin
            if (do_pop) begin
                act_d = mem_q[head_q];
            end else begin
                act_d = act_q;
            end
        end else if (bus.STEP) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (bus.MODE) begin
                    act_d[c*WIDTH +: WIDTH] = {act_q[c*WIDTH +: (WIDTH-1)], 1'b0};
                end else begin
                    act_d[c*WIDTH +: WIDTH] = {act_q[c*WIDTH +: (WIDTH-1)],
                                               act_q[c*WIDTH + WIDTH - 1]};
                end
            end
        end else begin
            act_d = act_q;
        end
    end

    // Queue storage write; contents are not reset, pointer reset hides them.
    always_ff @(posedge CLK) begin
        if (do_push && !RST) begin
            mem_q[tail_q] <= shadow_d;
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge CLK) begin
        if (RST) begin
            shadow_q <= {NW{1'b0}};
            head_q   <= {PW{1'b0}};
            tail_q   <= {PW{1'b0}};
            count_q  <= {KW{1'b0}};
            act_q    <= {NW{1'b0}};
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            if (do_pop) begin
                head_q <= head_q + PW'(1);
            end
            if (do_push) begin
                tail_q <= tail_q + PW'(1);
            end
            count_q <= count_d;
            act_q   <= act_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Serial taps are the MSB of each active register.
    always_comb begin
        bus.SER = {CHANNELS{1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            bus.SER[c] = act_q[c*WIDTH + WIDTH - 1];
        end
    end

    assign bus.Q     = act_q;
    assign bus.COUNT = count_q;
    assign bus.FULL  = (count_q == FULL_CNT);
    assign bus.EMPTY = (count_q == {KW{1'b0}});
    assign bus.OVF   = ovf_q;
    assign bus.UNF   = unf_q;
endmodule
